// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: state encoding, mode codes and
// default iteration geometry.
package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ITER = 3'd2,
      ST_GAIN = 3'd3,
      ST_DONE = 3'd4
   } cordic_state_e;

   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   localparam int unsigned N_ITER_DEF = 16;
   localparam int unsigned IDX_W_DEF  = 5;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration counter for the CORDIC sequencer: up-counter with synchronous clear (priority over
// enable) and a terminal-count flag at N_ITER-1.
module cordic_iter_cnt #(
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned N_ITER = 16
) (
   input  logic             C,
   input  logic             R,
   input  logic             clr,
   input  logic             en,
   output logic [IDX_W-1:0] cnt,
   output logic             tc
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITER - 1);

   always_ff @(posedge C) begin
      if (R || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + IDX_W'(1);
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the iterative CORDIC X/Y/Z datapath. Define CORDIC_GAIN_COMP_EN to add the
// one-cycle GAIN state and its gain_ce strobe between the last iteration and DONE.
module cordic_iter_ctrl
   import cordic_pkg::*;
#(
   parameter int unsigned N_ITER = N_ITER_DEF,
   parameter int unsigned IDX_W  = IDX_W_DEF
) (
   input  logic             C,
   input  logic             R,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic             z_sign,
   input  logic             y_sign,
   output logic             load,
   output logic             ce,
   output logic [IDX_W-1:0] iter_idx,
   output logic             dir,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready
`ifdef CORDIC_GAIN_COMP_EN
   ,
   output logic             gain_ce
`endif
);

   cordic_state_e    state, state_d;
   logic             mode_q;
   logic [IDX_W-1:0] cnt;
   logic             tc;
   logic             cnt_clr;
   logic             cnt_en;

   // Clearing on LOAD and on the last iteration keeps iter_idx within 0..N_ITER-1.
   assign cnt_en  = (state == ST_ITER);
   assign cnt_clr = (state == ST_LOAD) || ((state == ST_ITER) && tc);

   cordic_iter_cnt #(
      .IDX_W  (IDX_W),
      .N_ITER (N_ITER)
   ) u_cnt (
      .C   (C),
      .R   (R),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (tc)
   );

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE: if (in_valid) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_ITER;
`ifdef CORDIC_GAIN_COMP_EN
         ST_ITER: if (tc) state_d = ST_GAIN;
`else
         ST_ITER: if (tc) state_d = ST_DONE;
`endif
         ST_GAIN: state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore strobes are decoded from the next state so they line up with the registered state.
   always_ff @(posedge C) begin
      if (R) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_ROT;
         in_ready  <= 1'b1;
         load      <= 1'b0;
         ce        <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
         gain_ce   <= 1'b0;
`endif
      end else begin
         state <= state_d;
         if ((state == ST_IDLE) && in_valid) begin
            mode_q <= mode;
         end
         in_ready  <= (state_d == ST_IDLE);
         load      <= (state_d == ST_LOAD);
         ce        <= (state_d == ST_LOAD) || (state_d == ST_ITER);
         busy      <= (state_d != ST_IDLE);
         out_valid <= (state_d == ST_DONE);
`ifdef CORDIC_GAIN_COMP_EN
         gain_ce   <= (state_d == ST_GAIN);
`endif
      end
   end

   assign iter_idx = (state == ST_ITER) ? cnt : '0;

   // Direction follows the live sign bits, so it is only valid during ITER.
   assign dir = (state == ST_ITER) && ((mode_q == MODE_VEC) ? y_sign : ~z_sign);

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Randomized bench for cordic_iter_ctrl against a cycles-since-accept reference model,
// plus directed latency and mid-operation reset checks.
module tb_cordic_iter_ctrl;

   localparam int unsigned N_ITER = 16;
   localparam int unsigned IDX_W  = 5;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int GAIN = 1;
`else
   localparam int GAIN = 0;
`endif
   // Phase numbering: -1 idle, 0 load, 1..N_ITER iterations, then optional gain, then done.
   localparam int DONE_PH = N_ITER + 1 + GAIN;

   logic             C = 1'b0;
   logic             R = 1'b1;
   logic             in_valid = 1'b0;
   logic             mode = 1'b0;
   logic             z_sign = 1'b0;
   logic             y_sign = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready, load, ce, dir, busy, out_valid, gain_ce_w;
   logic [IDX_W-1:0] iter_idx;

   int total = 0;
   int bad = 0;
   int ph = -1;
   bit m_mode = 1'b0;

   always #5 C = ~C;

   cordic_iter_ctrl #(
      .N_ITER (N_ITER),
      .IDX_W  (IDX_W)
   ) dut (
      .C         (C),
      .R         (R),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .z_sign    (z_sign),
      .y_sign    (y_sign),
      .load      (load),
      .ce        (ce),
      .iter_idx  (iter_idx),
      .dir       (dir),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef CORDIC_GAIN_COMP_EN
      ,
      .gain_ce   (gain_ce_w)
`endif
   );
`ifndef CORDIC_GAIN_COMP_EN
   assign gain_ce_w = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      bit in_iter;
      bit exp_dir;
      int exp_idx;
      in_iter = (ph >= 1) && (ph <= int'(N_ITER));
      exp_idx = in_iter ? ph - 1 : 0;
      exp_dir = in_iter ? (m_mode ? y_sign : !z_sign) : 1'b0;
      check("in_ready", 32'(in_ready), 32'(ph == -1));
      check("busy", 32'(busy), 32'(ph != -1));
      check("load", 32'(load), 32'(ph == 0));
      check("ce", 32'(ce), 32'((ph >= 0) && (ph <= int'(N_ITER))));
      check("iter_idx", 32'(iter_idx), 32'(exp_idx));
      check("dir", 32'(dir), 32'(exp_dir));
      check("gain_ce", 32'(gain_ce_w), 32'((GAIN == 1) && (ph == int'(N_ITER) + 1)));
      check("out_valid", 32'(out_valid), 32'(ph == DONE_PH));
   endtask

   task automatic model_edge();
      if (R) begin
         ph = -1;
         m_mode = 1'b0;
      end else if (ph == -1) begin
         if (in_valid) begin
            ph = 0;
            m_mode = mode;
         end
      end else if (ph == DONE_PH) begin
         if (out_ready) ph = -1;
      end else begin
         ph++;
      end
   endtask

   // Called at a falling edge with inputs already applied.
   task automatic step();
      #1;
      check_all();
      @(posedge C);
      model_edge();
      @(negedge C);
   endtask

   initial begin
      int lat;
      int guard;
      R = 1'b1;
      repeat (2) @(posedge C);
      @(negedge C);
      R = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ce", 32'(ce), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_iter_idx", 32'(iter_idx), 32'd0);
      @(negedge C);

      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         mode      = ($urandom_range(0, 1) == 1);
         z_sign    = ($urandom_range(0, 1) == 1);
         y_sign    = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 3) == 0);
         R         = ($urandom_range(0, 199) == 0);
         step();
      end

      // Directed rotation: latency from accept edge to first out_valid.
      R = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step();
      R = 1'b0; in_valid = 1'b1; mode = 1'b0; z_sign = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      check("latency", 32'(lat), 32'(N_ITER + 1 + GAIN));

      // Backpressure for 10 cycles, then release.
      repeat (10) step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release", 32'(in_ready), 32'd1);

      // Reset while iter_idx == 7, then restart from 0.
      in_valid = 1'b1; mode = 1'b1;
      step();
      in_valid = 1'b0;
      guard = 0;
      while (!(ce && !load && iter_idx == 5'd7) && guard < 100) begin
         step();
         guard++;
      end
      check("reach_idx7", 32'(guard < 100), 32'd1);
      R = 1'b1;
      step();
      R = 1'b0;
      check("midrst_ce", 32'(ce), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("restart_idx", 32'(iter_idx), 32'd0);
      check("restart_ce", 32'(ce), 32'd1);
      repeat (30) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
